// File: rtl/drbg_field_scheduler.sv
// Field-synchronous scheduler for hash_drbg_sha256: reseeds on V edges, prefetches
// DRBG blocks into two ping-pong banks and serves one cut position per active line.
module drbg_field_scheduler #(
   parameter int DATA_WIDTH_IN  = 256,
   parameter int DATA_WIDTH_OUT = 8,
   parameter int RESEED_FIELDS  = 1,
   parameter int SEED_TIMEOUT   = 4096
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      H,
   input  logic                      V,
   input  logic                      init_ready,
   input  logic                      next_bits_ready,
   input  logic [DATA_WIDTH_IN-1:0]  random_bits,
   input  logic                      generator_busy,
   output logic                      next_seed,
   output logic                      next_bits,
   output logic [DATA_WIDTH_OUT-1:0] cut_position,
   output logic                      cut_valid,
   output logic                      underrun,
   output logic                      timeout,
   output logic [15:0]               field_count,
   output logic [2:0]                o_dbg_state
);

   localparam int NBYTES = DATA_WIDTH_IN / DATA_WIDTH_OUT;
   localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int TW     = $clog2(SEED_TIMEOUT + 1);
   localparam int RW     = (RESEED_FIELDS > 1) ? $clog2(RESEED_FIELDS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SEED_REQ, S_SEED_WAIT, S_FILL_REQ, S_FILL_WAIT, S_RUN
   } state_t;

   state_t                                   r_state;
   logic [NBYTES-1:0][DATA_WIDTH_OUT-1:0]    r_bank [2];
   logic [1:0]                               r_full;
   logic                                     r_ptr;
   logic [IW-1:0]                            r_idx;
   logic                                     r_tgt;
   logic                                     r_pending;
   logic                                     r_halted;
   logic [TW-1:0]                            r_tmo_cnt;
   logic [RW-1:0]                            r_reseed_cnt;
   logic                                     r_v_d, r_h_d;
   logic                                     r_next_seed, r_next_bits, r_cut_valid;
   logic                                     r_underrun, r_timeout;
   logic [DATA_WIDTH_OUT-1:0]                r_cut_position;
   logic [15:0]                              r_field_count;

   logic w_v_rise, w_h_rise, w_fill_state, w_serve, w_latch, w_empty_avail, w_target;
   logic w_tmo_hit;
   logic [DATA_WIDTH_OUT-1:0] w_cur_byte;

   assign w_v_rise      = V & ~r_v_d;
   assign w_h_rise      = H & ~r_h_d;
   assign w_fill_state  = (r_state == S_FILL_REQ) || (r_state == S_FILL_WAIT) || (r_state == S_RUN);
   assign w_serve       = w_h_rise & ~V & w_fill_state;
   assign w_latch       = next_bits_ready & r_pending & w_fill_state;
   assign w_empty_avail = ~r_full[0] | ~r_full[1];
   // Refill the bank that will be served next before the standby bank.
   assign w_target      = r_full[r_ptr] ? ~r_ptr : r_ptr;
   assign w_tmo_hit     = (r_tmo_cnt == TW'(SEED_TIMEOUT - 1));
   assign w_cur_byte    = r_bank[r_ptr][r_idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_bank[0]      <= '0;
         r_bank[1]      <= '0;
         r_full         <= 2'b00;
         r_ptr          <= 1'b0;
         r_idx          <= '0;
         r_tgt          <= 1'b0;
         r_pending      <= 1'b0;
         r_halted       <= 1'b0;
         r_tmo_cnt      <= '0;
         r_reseed_cnt   <= '0;
         r_v_d          <= 1'b0;
         r_h_d          <= 1'b0;
         r_next_seed    <= 1'b0;
         r_next_bits    <= 1'b0;
         r_cut_valid    <= 1'b0;
         r_underrun     <= 1'b0;
         r_timeout      <= 1'b0;
         r_cut_position <= '0;
         r_field_count  <= '0;
      end else begin
         r_v_d       <= V;
         r_h_d       <= H;
         r_next_seed <= 1'b0;
         r_next_bits <= 1'b0;
         r_cut_valid <= 1'b0;
         if (!enable) begin
            r_state   <= S_IDLE;
            r_full    <= 2'b00;
            r_pending <= 1'b0;
            r_ptr     <= 1'b0;
            r_idx     <= '0;
            r_halted  <= 1'b0;
         end else if (w_v_rise && (r_state != S_IDLE || !r_halted)) begin
            // New field: drop everything, including any in-flight block request.
            r_field_count <= r_field_count + 16'd1;
            r_state       <= S_SEED_REQ;
            r_full        <= 2'b00;
            r_pending     <= 1'b0;
            r_ptr         <= 1'b0;
            r_idx         <= '0;
         end else begin
            if (w_latch) begin
               r_bank[r_tgt] <= random_bits;
               r_full[r_tgt] <= 1'b1;
               r_pending     <= 1'b0;
            end
            if (w_serve) begin
               if (r_full[r_ptr]) begin
                  r_cut_position <= w_cur_byte;
                  r_cut_valid    <= 1'b1;
                  if (r_idx == IW'(NBYTES - 1)) begin
                     r_full[r_ptr] <= 1'b0;
                     r_ptr         <= ~r_ptr;
                     r_idx         <= '0;
                  end else begin
                     r_idx <= r_idx + IW'(1);
                  end
               end else begin
                  r_underrun <= 1'b1;
               end
            end
            case (r_state)
               S_IDLE: ;
               S_SEED_REQ: begin
                  r_tmo_cnt    <= '0;
                  r_reseed_cnt <= (r_reseed_cnt == RW'(RESEED_FIELDS - 1)) ? '0 : r_reseed_cnt + RW'(1);
                  if (r_reseed_cnt == '0) begin
                     r_next_seed <= 1'b1;
                     r_state     <= S_SEED_WAIT;
                  end else begin
                     r_state <= S_FILL_REQ;
                  end
               end
               S_SEED_WAIT: begin
                  // init_ready is stale while the request is still on the wire.
                  if (!r_next_seed && init_ready && !generator_busy) begin
                     r_state <= S_FILL_REQ;
                  end else if (w_tmo_hit) begin
                     r_timeout <= 1'b1;
                     r_halted  <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     r_tmo_cnt <= r_tmo_cnt + TW'(1);
                  end
               end
               S_FILL_REQ: begin
                  if (w_empty_avail) begin
                     r_next_bits <= 1'b1;
                     r_pending   <= 1'b1;
                     r_tgt       <= w_target;
                     r_tmo_cnt   <= '0;
                     r_state     <= S_FILL_WAIT;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
               S_FILL_WAIT: begin
                  if (w_latch) begin
                     r_state <= S_FILL_REQ;
                  end else if (w_tmo_hit) begin
                     r_timeout <= 1'b1;
                     r_halted  <= 1'b1;
                     r_pending <= 1'b0;
                     r_state   <= S_IDLE;
                  end else begin
                     r_tmo_cnt <= r_tmo_cnt + TW'(1);
                  end
               end
               S_RUN: begin
                  if (!r_pending && w_empty_avail && !generator_busy) begin
                     r_next_bits <= 1'b1;
                     r_pending   <= 1'b1;
                     r_tgt       <= w_target;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign next_seed    = r_next_seed;
   assign next_bits    = r_next_bits;
   assign cut_position = r_cut_position;
   assign cut_valid    = r_cut_valid;
   assign underrun     = r_underrun;
   assign timeout      = r_timeout;
   assign field_count  = r_field_count;
   assign o_dbg_state  = r_state;

endmodule
